// File: rtl/pair_match_ctl_pkg.sv
// Shared card-state encodings and FSM state type for the pair-matching controller.
// The regfile and the press checker use the same card encodings.
package pair_match_ctl_pkg;

  localparam int unsigned CARD_STATE_W = 2;

  typedef enum logic [CARD_STATE_W-1:0] {
    CARD_HIDDEN  = 2'd0,
    CARD_SHOWN   = 2'd1,
    CARD_MATCHED = 2'd2
  } card_state_t;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SHOW_A    = 4'd1,
    ST_FIRST     = 4'd2,
    ST_SHOW_B    = 4'd3,
    ST_COMPARE   = 4'd4,
    ST_MATCH_A   = 4'd5,
    ST_MATCH_B   = 4'd6,
    ST_WAIT_HIDE = 4'd7,
    ST_HIDE_A    = 4'd8,
    ST_HIDE_B    = 4'd9,
    ST_DONE      = 4'd10
  } fsm_state_t;

  // Counter width able to hold delay-1; a delay of one still needs one bit.
  function automatic int unsigned timer_width(input int unsigned delay);
    return (delay > 1) ? $clog2(delay) : 1;
  endfunction

endpackage

// File: rtl/pair_match_ctl_hide_timer.sv
// Mismatch display timer: cleared by load, counts up while count is high,
// and flags expiry once DELAY cycles have been counted.
module hide_timer
  import pair_match_ctl_pkg::*;
#(
  parameter int unsigned DELAY = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int unsigned CNT_W = timer_width(DELAY);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (count && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/pair_match_ctl.sv
// Memory-game pair matcher: shows two clicked cards, then marks them matched
// or hides them again after a display delay, and tracks game completion.
module pair_match_ctl
  import pair_match_ctl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned STATE_W    = 2,
  parameter int unsigned NUM_W      = 6,
  parameter int unsigned HIDE_DELAY = 65_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_W-1:0]   num_of_cards,
  input  logic               flip_valid,
  input  logic [ADDR_W-1:0]  flip_address,
  input  logic [COLOR_W-1:0] flip_color,
  output logic               flip_ready,
  output logic               wr_req,
  output logic [ADDR_W-1:0]  wr_address,
  output logic [STATE_W-1:0] wr_state,
  input  logic               wr_gnt,
  output logic [NUM_W-2:0]   pairs_found,
  output logic               busy,
  output logic               game_done
);

  localparam logic [STATE_W-1:0] WS_HIDDEN  = STATE_W'(CARD_HIDDEN);
  localparam logic [STATE_W-1:0] WS_SHOWN   = STATE_W'(CARD_SHOWN);
  localparam logic [STATE_W-1:0] WS_MATCHED = STATE_W'(CARD_MATCHED);

  fsm_state_t         state;
  logic [ADDR_W-1:0]  addr_a;
  logic [ADDR_W-1:0]  addr_b;
  logic [COLOR_W-1:0] color_a;
  logic [COLOR_W-1:0] color_b;

  logic             timer_rst;
  logic             timer_load;
  logic             timer_count;
  logic             hide_expired;
  logic [NUM_W-1:0] pairs_next;
  logic [NUM_W-1:0] pair_target;

  assign timer_rst   = rst || start;
  assign timer_load  = (state == ST_COMPARE);
  assign timer_count = (state == ST_WAIT_HIDE) && !hide_expired;

  // Computed at full width so a wrapped count can never fake a finished game.
  assign pairs_next  = {1'b0, pairs_found} + NUM_W'(1);
  assign pair_target = num_of_cards >> 1;

  hide_timer #(
    .DELAY(HIDE_DELAY)
  ) u_hide_timer (
    .clk    (clk),
    .rst    (timer_rst),
    .load   (timer_load),
    .count  (timer_count),
    .expired(hide_expired)
  );

  always_ff @(posedge clk) begin
    if (rst || start) begin
      state       <= ST_IDLE;
      flip_ready  <= 1'b1;
      wr_req      <= 1'b0;
      wr_address  <= '0;
      wr_state    <= '0;
      busy        <= 1'b0;
      game_done   <= 1'b0;
      pairs_found <= '0;
      addr_a      <= '0;
      addr_b      <= '0;
      color_a     <= '0;
      color_b     <= '0;
    end else begin
      game_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (flip_valid) begin
            addr_a     <= flip_address;
            color_a    <= flip_color;
            wr_req     <= 1'b1;
            wr_address <= flip_address;
            wr_state   <= WS_SHOWN;
            flip_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SHOW_A;
          end
        end
        ST_SHOW_A: begin
          if (wr_gnt) begin
            wr_req     <= 1'b0;
            flip_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          // A second click on the already-shown card is consumed and ignored.
          if (flip_valid && (flip_address != addr_a)) begin
            addr_b     <= flip_address;
            color_b    <= flip_color;
            wr_req     <= 1'b1;
            wr_address <= flip_address;
            wr_state   <= WS_SHOWN;
            flip_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SHOW_B;
          end
        end
        ST_SHOW_B: begin
          if (wr_gnt) begin
            wr_req <= 1'b0;
            state  <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (color_a == color_b) begin
            wr_req     <= 1'b1;
            wr_address <= addr_a;
            wr_state   <= WS_MATCHED;
            state      <= ST_MATCH_A;
          end else begin
            state <= ST_WAIT_HIDE;
          end
        end
        ST_MATCH_A: begin
          if (wr_gnt) begin
            wr_address <= addr_b;
            state      <= ST_MATCH_B;
          end
        end
        ST_MATCH_B: begin
          if (wr_gnt) begin
            wr_req      <= 1'b0;
            busy        <= 1'b0;
            pairs_found <= pairs_next[NUM_W-2:0];
            if (pairs_next == pair_target) begin
              game_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              flip_ready <= 1'b1;
              state      <= ST_IDLE;
            end
          end
        end
        ST_WAIT_HIDE: begin
          if (hide_expired) begin
            wr_req     <= 1'b1;
            wr_address <= addr_a;
            wr_state   <= WS_HIDDEN;
            state      <= ST_HIDE_A;
          end
        end
        ST_HIDE_A: begin
          if (wr_gnt) begin
            wr_address <= addr_b;
            state      <= ST_HIDE_B;
          end
        end
        ST_HIDE_B: begin
          if (wr_gnt) begin
            wr_req     <= 1'b0;
            busy       <= 1'b0;
            flip_ready <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state      <= ST_IDLE;
          wr_req     <= 1'b0;
          busy       <= 1'b0;
          flip_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_match_ctl.sv
// Self-checking bench for pair_match_ctl: directed scenarios plus random play,
// checked against a transaction-level model of expected regfile writes.
module tb_pair_match_ctl;

  localparam int HIDE = 10;
  localparam logic [1:0] S_HIDDEN  = 2'd0;
  localparam logic [1:0] S_SHOWN   = 2'd1;
  localparam logic [1:0] S_MATCHED = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] num_of_cards = 6'd4;
  logic       flip_valid = 1'b0;
  logic [4:0] flip_address = '0;
  logic [3:0] flip_color = '0;
  logic       flip_ready;
  logic       wr_req;
  logic [4:0] wr_address;
  logic [1:0] wr_state;
  logic       wr_gnt = 1'b1;
  logic [4:0] pairs_found;
  logic       busy;
  logic       game_done;

  pair_match_ctl #(
    .ADDR_W(5), .COLOR_W(4), .STATE_W(2), .NUM_W(6), .HIDE_DELAY(HIDE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_of_cards(num_of_cards),
    .flip_valid(flip_valid), .flip_address(flip_address), .flip_color(flip_color),
    .flip_ready(flip_ready), .wr_req(wr_req), .wr_address(wr_address),
    .wr_state(wr_state), .wr_gnt(wr_gnt), .pairs_found(pairs_found),
    .busy(busy), .game_done(game_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [1:0] s;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  gd_seen = 0;
  bit  rand_gnt = 1'b0;

  // Reference model of one game
  bit         m_has_a;
  logic [4:0] m_a;
  logic [3:0] m_ac;
  int         m_pairs;
  bit         m_done;
  int         m_games;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every granted request must be the next expected write.
  logic       p_req = 1'b0, p_gnt = 1'b0, p_abort = 1'b1;
  logic [4:0] p_addr = '0;
  logic [1:0] p_st = '0;
  int         last_cyc = 0;
  logic [1:0] last_st = S_HIDDEN;

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!rst) begin
      if (game_done === 1'b1) gd_seen++;
      if (p_req && !p_gnt && !p_abort) begin
        check("hold_req", wr_req, 1);
        check("hold_addr", wr_address, p_addr);
        check("hold_state", wr_state, p_st);
      end
      if (wr_req === 1'b1 && wr_gnt && !start) begin
        n_vec++;
        assert (exp_q.size() > 0)
        else begin
          n_err++;
          $error("FAIL spurious_write observed addr=%0d state=%0d expected none", wr_address, wr_state);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_address", wr_address, e.a);
          check("wr_state", wr_state, e.s);
          if (e.s == S_HIDDEN && last_st == S_SHOWN && !rand_gnt)
            check("hide_gap", cyc - last_cyc, HIDE + 2);
          last_cyc = cyc;
          last_st  = e.s;
        end
      end
    end
    p_req   = wr_req;
    p_gnt   = wr_gnt;
    p_abort = rst || start;
    p_addr  = wr_address;
    p_st    = wr_state;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_gnt) wr_gnt = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic [4:0] a, input logic [1:0] s);
    wr_t e;
    e.a = a;
    e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_has_a = 0; m_a = '0; m_ac = '0; m_pairs = 0; m_done = 0;
    exp_q.delete();
  endtask

  task automatic model_flip(input logic [4:0] a, input logic [3:0] c);
    if (!m_has_a) begin
      m_has_a = 1; m_a = a; m_ac = c;
      push(a, S_SHOWN);
    end else if (a != m_a) begin
      push(a, S_SHOWN);
      if (c == m_ac) begin
        push(m_a, S_MATCHED);
        push(a, S_MATCHED);
        m_pairs++;
        if (m_pairs == int'(num_of_cards) / 2) begin
          m_done = 1;
          m_games++;
        end
      end else begin
        push(m_a, S_HIDDEN);
        push(a, S_HIDDEN);
      end
      m_has_a = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_flip(input logic [4:0] a, input logic [3:0] c);
    drain();
    check("flip_ready", flip_ready, !m_done);
    flip_valid = 1'b1; flip_address = a; flip_color = c;
    step();
    flip_valid = 1'b0;
    if (!m_done) model_flip(a, c);
  endtask

  task automatic check_settled();
    drain();
    check("pairs_found", pairs_found, m_pairs);
    check("busy_settled", busy, 0);
    check("wr_req_settled", wr_req, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_reset();
    check("start_wr_req", wr_req, 0);
    check("start_pairs", pairs_found, 0);
    check("start_flip_ready", flip_ready, 1);
    check("start_busy", busy, 0);
  endtask

  initial begin
    m_games = 0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_flip_ready", flip_ready, 1);
    check("rst_wr_req", wr_req, 0);
    check("rst_busy", busy, 0);
    check("rst_pairs", pairs_found, 0);
    check("rst_game_done", game_done, 0);

    // Matching pair
    do_flip(5'd3, 4'd5);
    do_flip(5'd7, 4'd5);
    check_settled();
    check("match_flip_ready", flip_ready, 1);

    // Mismatch with hide delay
    do_start();
    do_flip(5'd2, 4'd1);
    do_flip(5'd4, 4'd6);
    check_settled();

    // Same card clicked twice
    do_flip(5'd5, 4'd1);
    do_flip(5'd5, 4'd1);
    do_flip(5'd6, 4'd2);
    check_settled();

    // Grant stall while showing B
    do_flip(5'd9, 4'd3);
    drain();
    wr_gnt = 1'b0;
    do_flip(5'd10, 4'd4);
    for (int i = 0; i < 4; i++) begin
      check("stall_req", wr_req, 1);
      check("stall_addr", wr_address, 10);
      check("stall_state", wr_state, S_SHOWN);
      check("stall_flip_ready", flip_ready, 0);
      step();
    end
    wr_gnt = 1'b1;
    check_settled();

    // Completion of a 4-card game
    do_start();
    do_flip(5'd1, 4'd3);
    do_flip(5'd2, 4'd3);
    do_flip(5'd4, 4'd7);
    do_flip(5'd6, 4'd7);
    check_settled();
    repeat (3) step();
    check("game_done_pulses", gd_seen, m_games);
    do_flip(5'd8, 4'd1);
    repeat (3) step();
    check("done_pairs", pairs_found, 2);
    check("done_flip_ready", flip_ready, 0);

    // Abort during the hide wait
    do_start();
    do_flip(5'd2, 4'd1);
    do_flip(5'd4, 4'd6);
    for (int i = 0; i < 50 && exp_q.size() > 2; i++) step();
    check("abort_sync", exp_q.size(), 2);
    repeat (6) step();
    do_start();
    repeat (15) step();
    check("abort_no_write", wr_req, 0);

    // Odd count: five cards need two pairs
    num_of_cards = 6'd5;
    do_flip(5'd1, 4'd2);
    do_flip(5'd3, 4'd2);
    do_flip(5'd5, 4'd9);
    do_flip(5'd7, 4'd9);
    check_settled();
    repeat (2) step();
    check("odd_done_pulses", gd_seen, m_games);

    // Single card: the game never finishes
    num_of_cards = 6'd1;
    do_start();
    do_flip(5'd1, 4'd2);
    do_flip(5'd3, 4'd2);
    check_settled();
    check("one_card_flip_ready", flip_ready, 1);
    num_of_cards = 6'd4;

    // rst beats start and flip mid-game
    do_start();
    do_flip(5'd3, 4'd1);
    rst = 1'b1; start = 1'b1; flip_valid = 1'b1;
    step();
    check("rst2_flip_ready", flip_ready, 1);
    check("rst2_wr_req", wr_req, 0);
    check("rst2_wr_address", wr_address, 0);
    check("rst2_busy", busy, 0);
    check("rst2_pairs", pairs_found, 0);
    rst = 1'b0; start = 1'b0; flip_valid = 1'b0;
    model_reset();
    step();

    // Random play with random grant stalls and occasional aborts
    rand_gnt = 1'b1;
    for (int n = 0; n < 80; n++) begin
      do_flip(5'($urandom_range(0, 7)), 4'($urandom_range(0, 2)));
      if (m_done || $urandom_range(0, 9) == 0) begin
        if (m_done) check_settled();
        do_start();
      end
    end
    check_settled();
    rand_gnt = 1'b0;
    wr_gnt = 1'b1;
    repeat (3) step();
    check("final_game_done_pulses", gd_seen, m_games);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
